// File: rtl/fsm_btn_debounce.sv
// fsm_btn_debounce: turns a raw, bouncing push-button into a clean debounced
// level (db_level) and a one-cycle press strobe (db_tick) for fsm_counter.en.
// The button is synchronised through two flops, then a four-state FSM
// qualifies press and release over STABLE_CYCLES cycles.
//
// Optional feature, macro AUTO_REPEAT_EN:
//   defined   - while the button stays held, db_tick also repeats every
//               REPEAT_CYCLES cycles
//   undefined - the repeat counter is absent; db_tick pulses only once per
//               qualified press
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | button released and debounced, db_level = 0
// CHK_PRESS | s2 went high, counting stable-high cycles before accepting
// HELD      | press accepted, db_level = 1 (auto-repeat runs here)
// CHK_REL   | s2 went low while held, counting stable-low cycles

module fsm_btn_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db_level,
    output logic db_tick
);

    localparam int MAX_CYC = (STABLE_CYCLES > REPEAT_CYCLES) ? STABLE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHK_PRESS = 2'd1,
        HELD      = 2'd2,
        CHK_REL   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1;
    logic             s2;
`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] rpt;
`endif

    // Two-flop synchroniser for the asynchronous button; the FSM only sees s2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Debounce FSM with registered level and strobe outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            db_level <= 1'b0;
            db_tick  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt      <= '0;
`endif
        end else begin
            // Strobe defaults low so it can never stretch past one cycle.
            db_tick <= 1'b0;
            case (state)
                IDLE: begin
                    db_level <= 1'b0;
                    if (s2) begin
                        state <= CHK_PRESS;
                        cnt   <= '0;
                    end
                end
                CHK_PRESS: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (cnt == STABLE_LAST) begin
                        state    <= HELD;
                        db_level <= 1'b1;
                        db_tick  <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rpt      <= '0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    db_level <= 1'b1;
                    if (!s2) begin
                        state <= CHK_REL;
                        cnt   <= '0;
                    end
`ifdef AUTO_REPEAT_EN
                    // Repeat period runs on every HELD cycle; it freezes in
                    // CHK_REL so a short glitch does not restart it.
                    if (rpt == REPEAT_LAST) begin
                        db_tick <= 1'b1;
                        rpt     <= '0;
                    end else begin
                        rpt <= rpt + 1'b1;
                    end
`endif
                end
                CHK_REL: begin
                    if (s2) begin
                        state <= HELD;
                    end else if (cnt == STABLE_LAST) begin
                        state    <= IDLE;
                        db_level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    db_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_btn_debounce.sv
// Directed bench for fsm_btn_debounce (STABLE_CYCLES=4, REPEAT_CYCLES=8).
// Expected edges are hand-derived; works with or without AUTO_REPEAT_EN.

module tb_fsm_btn_debounce;

`ifdef AUTO_REPEAT_EN
    localparam int RP       = 8;
    localparam int TICK_GL  = 5;
    localparam int NUM_EXP  = 5;
`else
    localparam int RP       = 0;
    localparam int TICK_GL  = 0;
    localparam int NUM_EXP  = 1;
`endif

    logic clk;
    logic reset;
    logic btn;
    logic db_level;
    logic db_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;

    fsm_btn_debounce #(
        .STABLE_CYCLES(4),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive btn=b for n edges; tick expected at edge tick_e (0 = none) and
    // then every RP edges; level starts at lvl0 and toggles at lvl_e (0 = never).
    task automatic run_seg(input string tag, input int n, input logic b,
                           input int tick_e, input logic lvl0, input int lvl_e);
        logic exp_t;
        logic exp_l;
        btn = b;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            exp_t = (tick_e != 0) &&
                    ((k == tick_e) || ((RP != 0) && (k > tick_e) && (((k - tick_e) % RP) == 0)));
            exp_l = ((lvl_e != 0) && (k >= lvl_e)) ? ~lvl0 : lvl0;
            chk($sformatf("%s_tick@%0d", tag, k), {31'd0, db_tick}, {31'd0, exp_t});
            chk($sformatf("%s_level@%0d", tag, k), {31'd0, db_level}, {31'd0, exp_l});
            if (db_tick) tick_cnt++;
        end
    endtask

    initial begin
        logic [5:0] bounce;
        bounce = 6'b011011;
        reset = 1'b1;
        btn   = 1'b1;

        // Reset held with button pressed: outputs stay low.
        run_seg("rst_hold", 10, 1'b1, 0, 1'b0, 0);
        reset = 1'b0;
        run_seg("rst_rel_press", 18, 1'b1, 7, 1'b0, 7);

        // Release after hold.
        run_seg("release1", 10, 1'b0, 0, 1'b1, 7);

        // Clean press, then a one-cycle low glitch while held.
        run_seg("press2", 10, 1'b1, 7, 1'b0, 7);
        run_seg("glitch_lo", 1, 1'b0, 0, 1'b1, 0);
        run_seg("glitch_hi", 8, 1'b1, TICK_GL, 1'b1, 0);
        run_seg("release2", 10, 1'b0, 0, 1'b1, 7);

        // Bounce: 1,1,0,1,1,0 x5 never qualifies.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 6; i++) begin
                run_seg($sformatf("bounce%0d_%0d", r, i), 1, bounce[i], 0, 1'b0, 0);
            end
        end
        run_seg("bounce_idle", 4, 1'b0, 0, 1'b0, 0);

        // Reset during CHK_PRESS, then full requalification.
        run_seg("pre_rst", 5, 1'b1, 0, 1'b0, 0);
        reset = 1'b1;
        #2;
        chk("rst_mid_tick", {31'd0, db_tick}, 32'd0);
        chk("rst_mid_level", {31'd0, db_level}, 32'd0);
        reset = 1'b0;
        run_seg("requal", 10, 1'b1, 7, 1'b0, 7);

        // Reset while HELD clears the level without waiting for a clock edge.
        reset = 1'b1;
        #2;
        chk("rst_held_level", {31'd0, db_level}, 32'd0);
        chk("rst_held_tick", {31'd0, db_tick}, 32'd0);
        btn   = 1'b0;
        reset = 1'b0;
        run_seg("post_rst_idle", 4, 1'b0, 0, 1'b0, 0);

        // Long hold: one tick without auto-repeat, five with it.
        tick_cnt = 0;
        run_seg("long_hold", 40, 1'b1, 7, 1'b0, 7);
        chk("num_ticks", tick_cnt, NUM_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
